adam_pause_sequencer: RTL and testbench

- Synthesizable pause-request generator for the ADAM pause protocol: a four-phase req/ack handshake between a pause master and a peripheral under test (e.g. a UART receiver).
- After a programmed delay it raises pause_req, waits for pause_ack, holds the pause for a programmed duration, releases it, then waits for pause_ack to drop.
- Used in system benches and power/clock-gating scenarios to exercise pause handling of peripherals.

---
 rtl/adam_pause_sequencer.sv | 142 ++++++++++++++
 tb/tb_adam_pause_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adam_pause_sequencer.sv
// adam_pause_sequencer
// Generates pause requests for the ADAM four-phase pause handshake:
// wait a programmed delay, raise pause_req, wait for pause_ack, hold the
// pause for a programmed duration, drop pause_req, then wait for pause_ack
// to fall before repeating (PERIODIC=1) or parking in DONE (PERIODIC=0).

module adam_pause_sequencer #(
    parameter int unsigned DELAY_CYCLES    = 1000,
    parameter int unsigned DURATION_CYCLES = 1000,
    parameter bit          PERIODIC        = 1'b1,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic pause_req,
    input  logic pause_ack,
    output logic paused,
    output logic done
);

    typedef enum logic [2:0] {
        ST_IDLE_DELAY = 3'd0,
        ST_REQ        = 3'd1,
        ST_HOLD       = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    // Terminal counts; the counter is cleared on every state change, so an
    // equality compare is enough and the counter can never wrap.
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST    = CNT_WIDTH'(DELAY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DURATION_LAST = CNT_WIDTH'(DURATION_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO      = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pause_req_q;
    logic                 pause_req_d;
    logic                 done_q;
    logic                 done_d;

    // State, counter and registered outputs; reset abandons any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE_DELAY;
            cnt_q       <= CNT_ZERO;
            pause_req_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pause_req_q <= pause_req_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter and output decode for the handshake sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pause_req_d = pause_req_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE_DELAY: begin
                // Only the delay phase is gated by enable; ack is ignored here.
                pause_req_d = 1'b0;
                if (enable) begin
                    if (cnt_q == DELAY_LAST) begin
                        cnt_d       = CNT_ZERO;
                        state_d     = ST_REQ;
                        pause_req_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_REQ: begin
                // No timeout: the request stays up until the peripheral answers.
                pause_req_d = 1'b1;
                if (pause_ack) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                // Duration counts every clock regardless of enable or ack.
                pause_req_d = 1'b1;
                if (cnt_q == DURATION_LAST) begin
                    pause_req_d = 1'b0;
                    cnt_d       = CNT_ZERO;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RELEASE: begin
                // Waiting for ack low guarantees req never rises on a stale ack.
                pause_req_d = 1'b0;
                if (!pause_ack) begin
                    cnt_d = CNT_ZERO;
                    if (PERIODIC) begin
                        state_d = ST_IDLE_DELAY;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            ST_DONE: begin
                pause_req_d = 1'b0;
                done_d      = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE_DELAY;
                cnt_d       = CNT_ZERO;
                pause_req_d = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    assign pause_req = pause_req_q;
    assign done      = done_q;
    assign paused    = pause_req_q & pause_ack;

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// Bench for adam_pause_sequencer: a periodic and a one-shot instance share
// clock, reset, enable and ack; a countdown-style model predicts req, done
// and paused for both, checked every falling edge, plus directed timing checks.

module tb_adam_pause_sequencer;

    localparam int DLY = 10;
    localparam int DUR = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic pause_ack;
    logic req0, paused0, done0;
    logic req1, paused1, done1;

    always #5 clk = ~clk;

    adam_pause_sequencer #(
        .DELAY_CYCLES(DLY), .DURATION_CYCLES(DUR), .PERIODIC(1'b1), .CNT_WIDTH(32)
    ) u_per (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pause_req(req0),
        .pause_ack(pause_ack), .paused(paused0), .done(done0)
    );

    adam_pause_sequencer #(
        .DELAY_CYCLES(DLY), .DURATION_CYCLES(DUR), .PERIODIC(1'b0), .CNT_WIDTH(8)
    ) u_one (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pause_req(req1),
        .pause_ack(pause_ack), .paused(paused1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = periodic, 1 = one-shot. delay_left counts down enabled
    // clocks to the request, hold_left counts down the pause duration.
    bit m_req[2];
    bit m_done[2];
    bit m_rel[2];
    int m_hold[2];
    int m_delay[2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_req[i]   <= 1'b0;
                m_done[i]  <= 1'b0;
                m_rel[i]   <= 1'b0;
                m_hold[i]  <= 0;
                m_delay[i] <= DLY;
            end else if (m_done[i]) begin
                m_req[i] <= 1'b0;
            end else if (m_rel[i]) begin
                if (!pause_ack) begin
                    m_rel[i] <= 1'b0;
                    if (i == 0) m_delay[i] <= DLY;
                    else        m_done[i]  <= 1'b1;
                end
            end else if (m_hold[i] > 0) begin
                m_hold[i] <= m_hold[i] - 1;
                if (m_hold[i] == 1) begin
                    m_req[i] <= 1'b0;
                    m_rel[i] <= 1'b1;
                end
            end else if (m_req[i]) begin
                if (pause_ack) m_hold[i] <= DUR;
            end else if (enable) begin
                m_delay[i] <= m_delay[i] - 1;
                if (m_delay[i] == 1) m_req[i] <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("per.req",    req0,    m_req[0]);
        chk("per.done",   done0,   m_done[0]);
        chk("per.paused", paused0, m_req[0] & pause_ack);
        chk("one.req",    req1,    m_req[1]);
        chk("one.done",   done1,   m_done[1]);
        chk("one.paused", paused1, m_req[1] & pause_ack);
    end

    // ack modes: 0 = echo model req, 1 = forced value, 2 = random toggling
    int   ack_mode;
    logic ack_force;

    task automatic drive_ack();
        case (ack_mode)
            0:       pause_ack = m_req[0];
            1:       pause_ack = ack_force;
            2:       if ($urandom_range(0, 3) == 0) pause_ack = ~pause_ack;
            default: pause_ack = 1'b0;
        endcase
    endtask

    task automatic set_mode(input int m, input logic v);
        ack_mode  = m;
        ack_force = v;
        drive_ack();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        drive_ack();
    endtask

    task automatic wait_req(input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (req0 !== val && n < 200);
    endtask

    int n;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        pause_ack = 1'b0;
        ack_mode  = 0;
        ack_force = 1'b0;
        repeat (3) tick();
        chk("reset req",    req0,    1'b0);
        chk("reset done",   done1,   1'b0);
        chk("reset paused", paused0, 1'b0);

        // Echoed ack: rise 10 after release, fall 6 after rise, next rise 11 later.
        rst_n = 1'b1;
        wait_req(1'b1, n);  chk_int("first rise",  n, 10);
        wait_req(1'b0, n);  chk_int("hold length", n, 6);
        wait_req(1'b1, n);  chk_int("second rise", n, 11);
        chk("oneshot done", done1, 1'b1);
        chk("oneshot req",  req1,  1'b0);

        // No ack for 50 clocks: request holds; then ack, fall 6 ticks later.
        set_mode(1, 1'b0);
        repeat (50) tick();
        chk("no timeout req", req0, 1'b1);
        set_mode(1, 1'b1);
        wait_req(1'b0, n);  chk_int("late ack hold", n, 6);
        set_mode(0, 1'b0);

        // Enable low for 7 clocks at delay count 4 stretches the delay.
        repeat (5) tick();
        enable = 1'b0;
        repeat (7) tick();
        enable = 1'b1;
        wait_req(1'b1, n);  chk_int("rise after enable gap", n, 6);

        // Enable low during HOLD does not stretch the pause.
        enable = 1'b0;
        wait_req(1'b0, n);  chk_int("hold with enable low", n, 6);
        enable = 1'b1;
        chk("oneshot still done", done1, 1'b1);
        chk("oneshot still idle", req1,  1'b0);

        // Ack held high 20 clocks after release: delay starts only after ack drops.
        set_mode(1, 1'b1);
        repeat (20) tick();
        chk("release waits ack", req0, 1'b0);
        set_mode(0, 1'b0);
        wait_req(1'b1, n);  chk_int("rise after ack drop", n, 11);

        // Reset in the middle of HOLD drops req immediately.
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async req drop",    req0,    1'b0);
        chk("async paused drop", paused0, 1'b0);
        chk("async done drop",   done1,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_req(1'b1, n);  chk_int("rise after reset", n, 10);

        // Random ack, enable and occasional resets against the model.
        ack_mode = 2;
        repeat (3000) begin
            tick();
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
